// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// One-bit full-subtractor (borrow) cell built from gate primitives.
// diff = a ^ b ^ bw ; borrow = (~a & b) | (~(a ^ b) & bw)
module Fullsubtractor (
  output wire  diff,
  output wire  borrow,
  input  logic inA,
  input  logic inB,
  input  logic inBorrow
);

  wire abXor;
  wire notA;
  wire notAbXor;
  wire genBorrow;
  wire propBorrow;

  xor gX1 (abXor, inA, inB);
  xor gX2 (diff, abXor, inBorrow);
  not gN1 (notA, inA);
  and gA1 (genBorrow, notA, inB);
  not gN2 (notAbXor, abXor);
  and gA2 (propBorrow, notAbXor, inBorrow);
  or  gO1 (borrow, genBorrow, propBorrow);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (inA - inB), LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inStart,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             outBusy,
  output logic             outDone,
  output logic [WIDTH-1:0] outDiff,
  output logic             outBorrow
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  ,
  output logic             outOverflow
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_q, bw_d;
  logic             borrow_q, borrow_d;
  logic             cellDiff;
  logic             cellBorrow;
  logic [WIDTH-1:0] msbMask;
  logic [WIDTH-1:0] resNext;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic             ovf_q, ovf_d;
`endif

  Fullsubtractor uCell (
    .diff    (cellDiff),
    .borrow  (cellBorrow),
    .inA     (a_q[0]),
    .inB     (b_q[0]),
    .inBorrow(bw_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bw_d     = bw_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    aMsb_d   = aMsb_q;
    bMsb_d   = bMsb_q;
    ovf_d    = ovf_q;
`endif
    // New difference bit enters at the MSB so the LSB-first stream lands in place.
    msbMask          = '0;
    msbMask[WIDTH-1] = cellDiff;
    resNext          = (res_q >> 1) | msbMask;

    case (state_q)
      IDLE: begin
        if (inStart) begin
          state_d = RUN;
          a_d     = inA;
          b_d     = inB;
          res_d   = '0;
          bw_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          aMsb_d  = inA[WIDTH-1];
          bMsb_d  = inB[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = resNext;
        bw_d  = cellBorrow;
        cnt_d = cnt_q + CNT_W'(1);
        // The final bit is processed on the same edge that publishes the result.
        if (cnt_q == LAST_BIT) begin
          state_d  = DONE;
          diff_d   = resNext;
          borrow_d = cellBorrow;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
          ovf_d    = (aMsb_q ^ bMsb_q) & (cellDiff ^ aMsb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      aMsb_q   <= 1'b0;
      bMsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bw_q     <= bw_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      aMsb_q   <= aMsb_d;
      bMsb_q   <= bMsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign outBusy   = (state_q == RUN);
  assign outDone   = (state_q == DONE);
  assign outDiff   = diff_q;
  assign outBorrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  assign outOverflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Overflow checks are compiled in only when SERIAL_SUBTRACTOR_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       start8 = 1'b0;
  logic [7:0] inA8 = '0;
  logic [7:0] inB8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;
  logic       start1 = 1'b0;
  logic [0:0] inA1 = '0;
  logic [0:0] inB1 = '0;
  logic       busy1, done1, borrow1;
  logic [0:0] diff1;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
  logic       ovf8, ovf1;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .resetN(resetN), .inStart(start8), .inA(inA8), .inB(inB8),
    .outBusy(busy8), .outDone(done8), .outDiff(diff8), .outBorrow(borrow8)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    , .outOverflow(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .resetN(resetN), .inStart(start1), .inA(inA1), .inB(inB1),
    .outBusy(busy1), .outDone(done1), .outDiff(diff1), .outBorrow(borrow1)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    , .outOverflow(ovf1)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Start one WIDTH=8 operation, count busy cycles until the done pulse, check the published result.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] expDiff, input logic expBorrow, input logic expOvf);
    int busyCnt;
    bit seen;
    busyCnt = 0;
    seen = 0;
    @(negedge clk);
    inA8 = a; inB8 = b; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    inA8 = 8'hFF; inB8 = 8'hFF;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done8) seen = 1;
      else if (busy8) busyCnt++;
    end
    checkOutput({tag, "_doneSeen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_busyCycles"}, 32'(busyCnt), 32'd8);
    checkOutput({tag, "_busyAtDone"}, 32'(busy8), 32'd0);
    checkOutput({tag, "_diff"}, 32'(diff8), 32'(expDiff));
    checkOutput({tag, "_borrow"}, 32'(borrow8), 32'(expBorrow));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    checkOutput({tag, "_ovf"}, 32'(ovf8), 32'(expOvf));
`else
    if (expOvf) begin end
`endif
    @(negedge clk);
    checkOutput({tag, "_donePulse1Cycle"}, 32'(done8), 32'd0);
    checkOutput({tag, "_diffHeld"}, 32'(diff8), 32'(expDiff));
  endtask

  task automatic applyStimulus1(input string tag, input logic a, input logic b,
                                input logic expDiff, input logic expBorrow, input logic expOvf);
    int busyCnt;
    bit seen;
    busyCnt = 0;
    seen = 0;
    @(negedge clk);
    inA1 = a; inB1 = b; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done1) seen = 1;
      else if (busy1) busyCnt++;
    end
    checkOutput({tag, "_doneSeen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_busyCycles"}, 32'(busyCnt), 32'd1);
    checkOutput({tag, "_diff"}, 32'(diff1), 32'(expDiff));
    checkOutput({tag, "_borrow"}, 32'(borrow1), 32'(expBorrow));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    checkOutput({tag, "_ovf"}, 32'(ovf1), 32'(expOvf));
`else
    if (expOvf) begin end
`endif
  endtask

  initial begin
    int doneCnt;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_diff", 32'(diff8), 32'd0);
    checkOutput("rst_borrow", 32'(borrow8), 32'd0);
    resetN = 1'b1;

    applyStimulus("op5A_23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    applyStimulus("op10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
    applyStimulus("op80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

    // Start requests during RUN and during the DONE cycle must be ignored.
    doneCnt = 0;
    @(negedge clk);
    inA8 = 8'h33; inB8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (i == 3) begin
        inA8 = 8'hFF; inB8 = 8'h00; start8 = 1'b1;
      end
      if (done8) begin
        doneCnt++;
        checkOutput("ign_diffAtDone", 32'(diff8), 32'h22);
        inA8 = 8'hFF; inB8 = 8'h00; start8 = 1'b1;
      end
    end
    start8 = 1'b0;
    checkOutput("ign_donePulses", 32'(doneCnt), 32'd1);
    checkOutput("ign_idleAfter", 32'(busy8), 32'd0);
    checkOutput("ign_diffHeld", 32'(diff8), 32'h22);

    applyStimulus("op5A_23b", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("hold_diff", 32'(diff8), 32'h37);

    // Reset in the fourth RUN cycle abandons the operation.
    @(negedge clk);
    inA8 = 8'h01; inB8 = 8'h02; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rstRun_busyBefore", 32'(busy8), 32'd1);
    resetN = 1'b0;
    @(negedge clk);
    checkOutput("rstRun_busy", 32'(busy8), 32'd0);
    checkOutput("rstRun_done", 32'(done8), 32'd0);
    checkOutput("rstRun_diff", 32'(diff8), 32'd0);
    checkOutput("rstRun_borrow", 32'(borrow8), 32'd0);
    resetN = 1'b1;
    doneCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) doneCnt++;
    end
    checkOutput("rstRun_noDone", 32'(doneCnt), 32'd0);
    applyStimulus("op01_02", 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);

    applyStimulus1("w1_0_1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus1("w1_1_1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
